// File: rtl/updown_mod_counter_pkg.sv
// ============================================================================
// Module   : cnt_pkg (package)
// Purpose  : Shared constants for the up/down modulo counter slice:
//            direction encodings, default WIDTH/MODULUS and a modulus
//            legality helper used at elaboration time.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cnt_pkg;

  // Direction encodings on up_dn
  localparam logic CNT_UP = 1'b1;
  localparam logic CNT_DN = 1'b0;

  // Default geometry
  localparam int CNT_WIDTH_DEF   = 4;
  localparam int CNT_MODULUS_DEF = 16;

  // True when MODULUS fits the range 2..2^WIDTH
  function automatic bit modulus_legal(input int width, input int modulus);
    return (modulus >= 2) && (longint'(modulus) <= (longint'(1) << width));
  endfunction

endpackage : cnt_pkg

`default_nettype wire

// File: rtl/updown_mod_counter_if.sv
// ============================================================================
// Module   : updown_mod_counter_if (interface)
// Purpose  : Control/status bundle of the up/down modulo counter.
// Ports    : master - drives en, up_dn, load, load_val, ovf_clr;
//                     observes count, tc, wrap_p, ovf
//            slave  - the counter side (mirror of master)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface updown_mod_counter_if
  import cnt_pkg::*;
#(
  parameter int WIDTH = CNT_WIDTH_DEF
);

  logic             en;
  logic             up_dn;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             ovf_clr;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             wrap_p;
  logic             ovf;

  modport master (
    output en, up_dn, load, load_val, ovf_clr,
    input  count, tc, wrap_p, ovf
  );

  modport slave (
    input  en, up_dn, load, load_val, ovf_clr,
    output count, tc, wrap_p, ovf
  );

endinterface : updown_mod_counter_if

`default_nettype wire

// File: rtl/updown_mod_counter_step.sv
// ============================================================================
// Module   : cnt_step
// Purpose  : Combinational next-count computation for one enabled step of
//            a modulo-MODULUS up/down counter, plus the boundary (wrap)
//            indication for the current direction.
// Ports    : i_count      - current count
//            i_up_dn      - direction (CNT_UP / CNT_DN)
//            o_next_count - count after one step, always 0..MODULUS-1
//            o_at_wrap    - current count sits on the boundary it would wrap
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cnt_step
  import cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH_DEF,
  parameter int MODULUS = CNT_MODULUS_DEF
) (
  input  wire logic [WIDTH-1:0] i_count,
  input  wire logic             i_up_dn,
  output logic      [WIDTH-1:0] o_next_count,
  output logic                  o_at_wrap
);

  localparam logic [WIDTH-1:0] C_MAX_COUNT = WIDTH'(MODULUS - 1);

  // The boundary is tested before the +1/-1, so the arithmetic never leaves
  // WIDTH bits even when MODULUS == 2^WIDTH.
  always_comb begin
    o_next_count = i_count;
    o_at_wrap    = 1'b0;
    if (i_up_dn == CNT_UP) begin
      if (i_count == C_MAX_COUNT) begin
        o_next_count = '0;
        o_at_wrap    = 1'b1;
      end else begin
        o_next_count = i_count + 1'b1;
      end
    end else begin
      if (i_count == '0) begin
        o_next_count = C_MAX_COUNT;
        o_at_wrap    = 1'b1;
      end else begin
        o_next_count = i_count - 1'b1;
      end
    end
  end

endmodule : cnt_step

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ============================================================================
// Module   : updown_mod_counter
// Purpose  : Loadable modulo-MODULUS up/down counter with terminal count,
//            registered wrap pulse and optional sticky overflow flag.
//            Update priority per edge: rst > load > en > hold.
// Ports    : clk     - clock, rising edge
//            rst     - synchronous active-high reset
//            bus     - updown_mod_counter_if.slave:
//                      en, up_dn, load, load_val, ovf_clr (in)
//                      count, tc, wrap_p, ovf (out)
// Config   : UPDOWN_CNT_STICKY_OVF_EN - when defined, ovf sets on every wrap
//            and holds until ovf_clr (set wins); otherwise ovf is 0 and
//            ovf_clr is ignored.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module updown_mod_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH_DEF,
  parameter int MODULUS = CNT_MODULUS_DEF
) (
  input wire logic            clk,
  input wire logic            rst,
  updown_mod_counter_if.slave bus
);

  generate
    if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("updown_mod_counter: MODULUS must lie in 2..2^WIDTH");
    end
  endgenerate

  localparam logic [WIDTH-1:0] C_MAX_COUNT = WIDTH'(MODULUS - 1);
  // One extra bit so MODULUS == 2^WIDTH is representable for the load check
  localparam logic [WIDTH:0]   C_MOD_EXT   = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_p_q, wrap_p_d;
  logic [WIDTH-1:0] w_step_count;
  logic [WIDTH-1:0] w_load_sat;
  logic             w_at_wrap;
  logic             w_tc;

  cnt_step #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_step (
    .i_count      (count_q),
    .i_up_dn      (bus.up_dn),
    .o_next_count (w_step_count),
    .o_at_wrap    (w_at_wrap)
  );

  // Out-of-range load values saturate to the top of the count range
  assign w_load_sat = ({1'b0, bus.load_val} < C_MOD_EXT) ? bus.load_val : C_MAX_COUNT;

  // A wrap happens exactly on an edge where tc is high
  assign w_tc = bus.en & ~bus.load & w_at_wrap;

  always_comb begin
    count_d = count_q;
    if (bus.load) begin
      count_d = w_load_sat;
    end else if (bus.en) begin
      count_d = w_step_count;
    end
    wrap_p_d = w_tc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q  <= '0;
      wrap_p_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      wrap_p_q <= wrap_p_d;
    end
  end

`ifdef UPDOWN_CNT_STICKY_OVF_EN
  logic ovf_q, ovf_d;

  // Set is applied last so a wrap on the same edge as ovf_clr keeps ovf high
  always_comb begin
    ovf_d = ovf_q;
    if (bus.ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (w_tc) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign bus.ovf = ovf_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = bus.ovf_clr;
  assign bus.ovf        = 1'b0;
`endif

  assign bus.count  = count_q;
  assign bus.tc     = w_tc;
  assign bus.wrap_p = wrap_p_q;

endmodule : updown_mod_counter

`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
// ============================================================================
// Module   : tb_updown_mod_counter
// Purpose  : Self-checking bench for updown_mod_counter (WIDTH=4, MODULUS=10)
//            against a modular-arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_updown_mod_counter;

  localparam int C_WIDTH = 4;
  localparam int C_MOD   = 10;
`ifdef UPDOWN_CNT_STICKY_OVF_EN
  localparam bit C_STICKY = 1'b1;
`else
  localparam bit C_STICKY = 1'b0;
`endif

  logic clk;
  logic rst;

  updown_mod_counter_if #(.WIDTH(C_WIDTH)) bus ();

  updown_mod_counter #(
    .WIDTH   (C_WIDTH),
    .MODULUS (C_MOD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Stimulus copies held by the bench
  bit s_rst, s_en, s_up, s_load, s_clr;
  int s_lv;

  // Reference model state
  int m_count = 0;
  bit m_wrap  = 1'b0;
  bit m_ovf   = 1'b0;

  task automatic apply(input bit r, input bit e, input bit u, input bit l,
                       input int lv, input bit c);
    s_rst = r; s_en = e; s_up = u; s_load = l; s_lv = lv; s_clr = c;
    rst          = r;
    bus.en       = e;
    bus.up_dn    = u;
    bus.load     = l;
    bus.load_val = 4'(lv);
    bus.ovf_clr  = c;
  endtask

  function automatic bit model_tc();
    return s_en && !s_load && (s_up ? (m_count == C_MOD - 1) : (m_count == 0));
  endfunction

  // Advance the model by one edge using the applied stimulus, then step
  // the clock and settle just after the edge.
  task automatic clock_edge();
    bit wrap_now;
    wrap_now = model_tc();
    if (s_rst) begin
      m_count = 0; m_wrap = 1'b0; m_ovf = 1'b0;
    end else begin
      if (s_load)
        m_count = (s_lv < C_MOD) ? s_lv : C_MOD - 1;
      else if (s_en)
        m_count = s_up ? (m_count + 1) % C_MOD : (m_count + C_MOD - 1) % C_MOD;
      m_wrap = wrap_now;
      if (C_STICKY) begin
        if (wrap_now)   m_ovf = 1'b1;
        else if (s_clr) m_ovf = 1'b0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 1, 1, 1, 5, 0);
    clock_edge();
    n_checks++;
    if (bus.count !== 4'd0) begin
      n_errors++; $display("FAIL reset_count: got %0d expected 0", bus.count);
    end
    n_checks++;
    if (bus.wrap_p !== 1'b0) begin
      n_errors++; $display("FAIL reset_wrap_p: got %0b expected 0", bus.wrap_p);
    end
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      n_errors++; $display("FAIL reset_ovf: got %0b expected 0", bus.ovf);
    end
  endtask

  task automatic test_count_up();
    int exp_seq [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    apply(1, 0, 1, 0, 0, 0);
    clock_edge();
    for (int i = 0; i < 12; i++) begin
      apply(0, 1, 1, 0, 0, 0);
      #1;
      n_checks++;
      if (bus.tc !== (m_count == 9)) begin
        n_errors++; $display("FAIL up_tc[%0d]: got %0b expected %0b", i, bus.tc, (m_count == 9));
      end
      clock_edge();
      n_checks++;
      if (bus.count !== 4'(exp_seq[i])) begin
        n_errors++; $display("FAIL up_count[%0d]: got %0d expected %0d", i, bus.count, exp_seq[i]);
      end
      n_checks++;
      if (bus.wrap_p !== (i == 9)) begin
        n_errors++; $display("FAIL up_wrap_p[%0d]: got %0b expected %0b", i, bus.wrap_p, (i == 9));
      end
    end
  endtask

  task automatic test_count_down();
    int exp_seq [2] = '{9, 8};
    apply(1, 0, 0, 0, 0, 0);
    clock_edge();
    for (int i = 0; i < 2; i++) begin
      apply(0, 1, 0, 0, 0, 0);
      clock_edge();
      n_checks++;
      if (bus.count !== 4'(exp_seq[i])) begin
        n_errors++; $display("FAIL dn_count[%0d]: got %0d expected %0d", i, bus.count, exp_seq[i]);
      end
      n_checks++;
      if (bus.wrap_p !== (i == 0)) begin
        n_errors++; $display("FAIL dn_wrap_p[%0d]: got %0b expected %0b", i, bus.wrap_p, (i == 0));
      end
    end
  endtask

  task automatic test_load();
    // Out-of-range value saturates; en is ignored
    apply(0, 1, 1, 1, 13, 0);
    clock_edge();
    n_checks++;
    if (bus.count !== 4'd9) begin
      n_errors++; $display("FAIL load_sat_count: got %0d expected 9", bus.count);
    end
    n_checks++;
    if (bus.wrap_p !== 1'b0) begin
      n_errors++; $display("FAIL load_sat_wrap_p: got %0b expected 0", bus.wrap_p);
    end
    // At the top with en/up set, load must mask tc and the wrap
    apply(0, 1, 1, 1, 3, 0);
    #1;
    n_checks++;
    if (bus.tc !== 1'b0) begin
      n_errors++; $display("FAIL load_tc_mask: got %0b expected 0", bus.tc);
    end
    clock_edge();
    n_checks++;
    if (bus.count !== 4'd3) begin
      n_errors++; $display("FAIL load_count: got %0d expected 3", bus.count);
    end
    n_checks++;
    if (bus.wrap_p !== 1'b0) begin
      n_errors++; $display("FAIL load_wrap_p: got %0b expected 0", bus.wrap_p);
    end
    // Hold with nothing asserted
    apply(0, 0, 0, 0, 7, 0);
    clock_edge();
    n_checks++;
    if (bus.count !== 4'd3) begin
      n_errors++; $display("FAIL hold_count: got %0d expected 3", bus.count);
    end
  endtask

  task automatic test_ovf();
    apply(1, 0, 1, 0, 0, 0);
    clock_edge();
    apply(0, 0, 1, 1, 9, 0);
    clock_edge();
    apply(0, 1, 1, 0, 0, 0);
    clock_edge();
    n_checks++;
    if (bus.ovf !== C_STICKY) begin
      n_errors++; $display("FAIL ovf_set: got %0b expected %0b", bus.ovf, C_STICKY);
    end
    apply(0, 0, 1, 0, 0, 0);
    clock_edge();
    n_checks++;
    if (bus.ovf !== C_STICKY) begin
      n_errors++; $display("FAIL ovf_hold: got %0b expected %0b", bus.ovf, C_STICKY);
    end
    apply(0, 0, 1, 1, 9, 0);
    clock_edge();
    apply(0, 1, 1, 0, 0, 1);
    clock_edge();
    n_checks++;
    if (bus.ovf !== C_STICKY) begin
      n_errors++; $display("FAIL ovf_set_wins: got %0b expected %0b", bus.ovf, C_STICKY);
    end
    apply(0, 0, 1, 0, 0, 1);
    clock_edge();
    n_checks++;
    if (bus.ovf !== 1'b0) begin
      n_errors++; $display("FAIL ovf_clr: got %0b expected 0", bus.ovf);
    end
  endtask

  task automatic test_dir_toggle();
    int exp_seq [4] = '{5, 4, 5, 4};
    apply(0, 0, 0, 1, 4, 0);
    clock_edge();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, (i % 2 == 0), 0, 0, 0);
      clock_edge();
      n_checks++;
      if (bus.count !== 4'(exp_seq[i])) begin
        n_errors++; $display("FAIL toggle_count[%0d]: got %0d expected %0d", i, bus.count, exp_seq[i]);
      end
    end
    // Reset on what would be a wrap edge: abandon count, no pulse after
    apply(0, 1, 1, 1, 9, 0);
    clock_edge();
    apply(1, 1, 1, 0, 0, 0);
    clock_edge();
    n_checks++;
    if (bus.count !== 4'd0 || bus.wrap_p !== 1'b0) begin
      n_errors++; $display("FAIL rst_mid_count: got count=%0d wrap_p=%0b expected count=0 wrap_p=0", bus.count, bus.wrap_p);
    end
    apply(0, 1, 1, 0, 0, 0);
    clock_edge();
    n_checks++;
    if (bus.count !== 4'd1 || bus.wrap_p !== 1'b0) begin
      n_errors++; $display("FAIL rst_resume: got count=%0d wrap_p=%0b expected count=1 wrap_p=0", bus.count, bus.wrap_p);
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 400; i++) begin
      apply(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            int'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));
      #1;
      n_checks++;
      if (bus.tc !== model_tc()) begin
        n_errors++; $display("FAIL rnd_tc[%0d]: got %0b expected %0b", i, bus.tc, model_tc());
      end
      clock_edge();
      n_checks++;
      if (bus.count !== 4'(m_count) || bus.wrap_p !== m_wrap || bus.ovf !== m_ovf) begin
        n_errors++;
        $display("FAIL rnd_state[%0d]: got count=%0d wrap_p=%0b ovf=%0b expected count=%0d wrap_p=%0b ovf=%0b",
                 i, bus.count, bus.wrap_p, bus.ovf, m_count, m_wrap, m_ovf);
      end
    end
  endtask

  initial begin
    apply(1, 0, 1, 0, 0, 0);
    @(negedge clk);
    test_reset();
    test_count_up();
    test_count_down();
    test_load();
    test_ovf();
    test_dir_toggle();
    test_back_to_back_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_updown_mod_counter

`default_nettype wire
